// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave exposing NREGS 32-bit registers with byte strobes.
// Write and read channels run as independent FSMs; all valid/ready outputs are flops.
module axi_lite_reg_slave #(
    parameter int NREGS  = 16,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [31:0]           s_wdata,
    input  logic [3:0]            s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ADDR_W-1:0]     s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [NREGS*32-1:0]   regs_flat
);
    localparam int IDX_W = $clog2(NREGS);

    typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    wstate_e                wstate_q, wstate_d;
    rstate_e                rstate_q, rstate_d;
    logic                   awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic                   bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]             bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [IDX_W-1:0]       awidx_q, awidx_d;
    logic                   aw_oor_q, aw_oor_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             wstrb_q, wstrb_d;
    logic [NREGS-1:0][31:0] regs_q, regs_d;

    logic             aw_hs, w_hs, ar_hs;
    logic [IDX_W-1:0] aw_idx, ar_idx;
    logic             aw_oor, ar_oor;
    logic             commit, c_oor;
    logic [IDX_W-1:0] c_idx;
    logic [31:0]      c_data;
    logic [3:0]       c_strb;
    logic             unused_addr_bits;

    assign aw_hs  = s_awvalid & awready_q;
    assign w_hs   = s_wvalid & wready_q;
    assign ar_hs  = s_arvalid & arready_q;
    assign aw_idx = s_awaddr[IDX_W+1:2];
    assign ar_idx = s_araddr[IDX_W+1:2];
    // Any set bit above the register window means the address is out of range.
    assign aw_oor = |s_awaddr[ADDR_W-1:IDX_W+2];
    assign ar_oor = |s_araddr[ADDR_W-1:IDX_W+2];
    assign unused_addr_bits = ^{s_awaddr[1:0], s_araddr[1:0]};

    always_comb begin
        wstate_d = wstate_q;
        awidx_d  = awidx_q;
        aw_oor_d = aw_oor_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        commit   = 1'b0;
        c_idx    = aw_idx;
        c_oor    = aw_oor;
        c_data   = s_wdata;
        c_strb   = s_wstrb;
        case (wstate_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit   = 1'b1;
                    wstate_d = W_RESP;
                end else if (aw_hs) begin
                    awidx_d  = aw_idx;
                    aw_oor_d = aw_oor;
                    wstate_d = W_HAVE_A;
                end else if (w_hs) begin
                    wdata_d  = s_wdata;
                    wstrb_d  = s_wstrb;
                    wstate_d = W_HAVE_D;
                end
            end
            W_HAVE_A: if (w_hs) begin
                commit   = 1'b1;
                c_idx    = awidx_q;
                c_oor    = aw_oor_q;
                wstate_d = W_RESP;
            end
            W_HAVE_D: if (aw_hs) begin
                commit   = 1'b1;
                c_data   = wdata_q;
                c_strb   = wstrb_q;
                wstate_d = W_RESP;
            end
            W_RESP: if (bvalid_q && s_bready) begin
                bvalid_d = 1'b0;
                wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = c_oor ? 2'b10 : 2'b00;
        end
        // Readys are decoded from the next state so they come straight out of flops.
        awready_d = (wstate_d == W_IDLE) || (wstate_d == W_HAVE_D);
        wready_d  = (wstate_d == W_IDLE) || (wstate_d == W_HAVE_A);
    end

    always_comb begin
        regs_d = regs_q;
        if (commit && !c_oor) begin
            for (int k = 0; k < 4; k++) begin
                if (c_strb[k]) regs_d[c_idx][8*k +: 8] = c_data[8*k +: 8];
            end
        end
    end

    // Reads sample regs_q, so a same-edge write is seen only by later reads.
    always_comb begin
        rstate_d = rstate_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        case (rstate_q)
            R_IDLE: if (ar_hs) begin
                rstate_d = R_DATA;
                rvalid_d = 1'b1;
                rdata_d  = ar_oor ? 32'h0 : regs_q[ar_idx];
                rresp_d  = ar_oor ? 2'b10 : 2'b00;
            end
            R_DATA: if (s_rready) begin
                rstate_d = R_IDLE;
                rvalid_d = 1'b0;
            end
            default: rstate_d = R_IDLE;
        endcase
        arready_d = (rstate_d == R_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rresp_q   <= 2'b00;
            rdata_q   <= 32'h0;
            awidx_q   <= '0;
            aw_oor_q  <= 1'b0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            regs_q    <= '0;
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            awidx_q   <= awidx_d;
            aw_oor_q  <= aw_oor_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            regs_q    <= regs_d;
        end
    end

    assign s_awready = awready_q;
    assign s_wready  = wready_q;
    assign s_arready = arready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_rvalid  = rvalid_q;
    assign s_rresp   = rresp_q;
    assign s_rdata   = rdata_q;
    assign regs_flat = regs_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Bench for axi_lite_reg_slave: directed corner cases plus concurrent random traffic,
// with a register-array reference model feeding response queues checked by a monitor.
module tb_axi_lite_reg_slave;
    localparam int NREGS  = 16;
    localparam int ADDR_W = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [ADDR_W-1:0]   s_awaddr, s_araddr;
    logic                s_awvalid, s_awready, s_wvalid, s_wready;
    logic [31:0]         s_wdata, s_rdata;
    logic [3:0]          s_wstrb;
    logic [1:0]          s_bresp, s_rresp;
    logic                s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
    logic [NREGS*32-1:0] regs_flat;

    axi_lite_reg_slave #(.NREGS(NREGS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .regs_flat(regs_flat)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mdl [NREGS];
    logic [1:0]  bq [$];
    logic [33:0] rq [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: handshake timeout (t=%0t)", nm, $time);
    endtask

    task automatic check_regs(input string nm);
        for (int i = 0; i < NREGS; i++)
            check($sformatf("%s_reg%0d", nm, i), regs_flat[32*i +: 32], mdl[i]);
    endtask

    function automatic logic in_range(input logic [31:0] a);
        return a < 32'(NREGS * 4);
    endfunction

    // Monitor: compares every B/R handshake against the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_bvalid && s_bready) begin
                if (bq.size() == 0) timeout("b_unexpected");
                else begin
                    check("bresp", 32'(s_bresp), 32'(bq.pop_front()));
                    check_regs("after_write");
                end
            end
            if (s_rvalid && s_rready) begin
                if (rq.size() == 0) timeout("r_unexpected");
                else begin
                    logic [33:0] e;
                    e = rq.pop_front();
                    check("rdata", s_rdata, e[31:0]);
                    check("rresp", 32'(s_rresp), 32'(e[33:32]));
                end
            end
        end
    end

    // skew > 0: W waits skew cycles; skew < 0: AW waits -skew cycles.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int skew, input int bhold);
        logic [1:0] eb;
        s_bready = 1'b0;
        fork
            begin
                int to = 0;
                if (skew < 0) begin repeat (-skew) @(posedge clk); #1; end
                s_awaddr = a; s_awvalid = 1'b1;
                forever begin
                    @(negedge clk);
                    if (s_awready) break;
                    if (++to > 50) begin timeout("aw_wait"); break; end
                end
                @(posedge clk); #1 s_awvalid = 1'b0;
            end
            begin
                int to = 0;
                if (skew > 0) begin repeat (skew) @(posedge clk); #1; end
                s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
                forever begin
                    @(negedge clk);
                    if (s_wready) break;
                    if (++to > 50) begin timeout("w_wait"); break; end
                end
                @(posedge clk); #1 s_wvalid = 1'b0;
            end
        join
        check("bvalid_latency", 32'(s_bvalid), 32'd1);
        eb = in_range(a) ? 2'b00 : 2'b10;
        if (in_range(a)) begin
            for (int k = 0; k < 4; k++)
                if (s[k]) mdl[a[5:2]][8*k +: 8] = d[8*k +: 8];
        end
        bq.push_back(eb);
        repeat (bhold) begin
            @(negedge clk);
            check("bhold_bvalid", 32'(s_bvalid), 32'd1);
            check("bhold_bresp", 32'(s_bresp), 32'(eb));
            check("bhold_awready", 32'(s_awready), 32'd0);
            check("bhold_wready", 32'(s_wready), 32'd0);
        end
        @(posedge clk); #1 s_bready = 1'b1;
        begin
            int to = 0;
            forever begin
                @(negedge clk);
                if (s_bvalid) break;
                if (++to > 50) begin timeout("b_wait"); break; end
            end
        end
        @(posedge clk); #1 s_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, input int rhold);
        logic [33:0] e;
        int to = 0;
        s_rready = 1'b0;
        s_araddr = a; s_arvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_arready) break;
            if (++to > 50) begin timeout("ar_wait"); break; end
        end
        e = in_range(a) ? {2'b00, mdl[a[5:2]]} : {2'b10, 32'h0};
        rq.push_back(e);
        @(posedge clk); #1 s_arvalid = 1'b0;
        check("rvalid_latency", 32'(s_rvalid), 32'd1);
        repeat (rhold) begin
            @(negedge clk);
            check("rhold_rvalid", 32'(s_rvalid), 32'd1);
            check("rhold_rdata", s_rdata, e[31:0]);
            check("rhold_arready", 32'(s_arready), 32'd0);
        end
        @(posedge clk); #1 s_rready = 1'b1;
        to = 0;
        forever begin
            @(negedge clk);
            if (s_rvalid) break;
            if (++to > 50) begin timeout("r_wait"); break; end
        end
        @(posedge clk); #1 s_rready = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        return 32'($urandom_range(0, NREGS + 2) * 4 + $urandom_range(0, 3));
    endfunction

    task automatic check_idle_outputs(input string nm);
        check({nm, "_awready"}, 32'(s_awready), 0);
        check({nm, "_wready"}, 32'(s_wready), 0);
        check({nm, "_arready"}, 32'(s_arready), 0);
        check({nm, "_bvalid"}, 32'(s_bvalid), 0);
        check({nm, "_rvalid"}, 32'(s_rvalid), 0);
        check({nm, "_bresp"}, 32'(s_bresp), 0);
        check({nm, "_rresp"}, 32'(s_rresp), 0);
        check({nm, "_rdata"}, s_rdata, 0);
        check_regs(nm);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
        s_bready = 0; s_araddr = '0; s_arvalid = 0; s_rready = 0;
        for (int i = 0; i < NREGS; i++) mdl[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset");
        @(negedge clk); rst_n = 1'b1;
        #1 check("ready_before_edge", 32'(s_awready), 32'd0);
        @(negedge clk);
        check("awready_rise", 32'(s_awready), 32'd1);
        check("wready_rise", 32'(s_wready), 32'd1);
        check("arready_rise", 32'(s_arready), 32'd1);
        @(posedge clk); #1;

        // Simultaneous AW/W
        axi_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0);
        check("word2", regs_flat[95:64], 32'hDEADBEEF);

        // W first, AW three cycles later, partial strobes
        axi_write(32'h04, 32'hAABBCCDD, 4'hF, 0, 0);
        fork
            axi_write(32'h04, 32'h11223344, 4'h5, -3, 0);
            repeat (4) begin
                @(negedge clk);
                check("no_early_write", regs_flat[63:32], 32'hAABBCCDD);
            end
        join
        check("strobe_merge", regs_flat[63:32], 32'hAA22CC44);
        axi_write(32'h04, 32'hFFFFFFFF, 4'h0, 2, 0);
        check("zero_strobe", regs_flat[63:32], 32'hAA22CC44);

        // Out of range
        axi_write(32'h40, 32'h12345678, 4'hF, 0, 0);
        axi_read(32'h40, 0);

        // Backpressure on both responses
        axi_write(32'h10, 32'h5A5A5A5A, 4'hF, 1, 5);
        axi_read(32'h10, 5);

        // Same-edge read/write to reg 3 returns the old value
        axi_write(32'h0C, 32'h1, 4'hF, 0, 0);
        fork
            axi_write(32'h0C, 32'h2, 4'hF, 0, 0);
            axi_read(32'h0C, 0);
        join
        axi_read(32'h0C, 0);
        check("reg3_new", regs_flat[127:96], 32'h2);

        // Concurrent random traffic
        fork
            for (int i = 0; i < 40; i++) begin
                axi_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 6) - 3, $urandom_range(0, 2));
                if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            end
            for (int i = 0; i < 40; i++) begin
                axi_read(rand_addr(), $urandom_range(0, 2));
                if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            end
        join
        check("bq_drained", 32'(bq.size()), 0);
        check("rq_drained", 32'(rq.size()), 0);

        // Reset while holding an address: the later W must not write
        s_awaddr = 32'h0; s_awvalid = 1'b1;
        @(negedge clk);
        check("hold_a_awready", 32'(s_awready), 32'd1);
        @(posedge clk); #1 s_awvalid = 1'b0;
        #2 rst_n = 1'b0;
        for (int i = 0; i < NREGS; i++) mdl[i] = 32'h0;
        #1 check_idle_outputs("midreset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        s_wdata = 32'hFFFFFFFF; s_wstrb = 4'hF; s_wvalid = 1'b1;
        @(negedge clk);
        check("post_reset_wready", 32'(s_wready), 32'd1);
        @(posedge clk); #1 s_wvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abandoned_bvalid", 32'(s_bvalid), 32'd0);
            check_regs("abandoned");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axi_lite_reg_slave.md
AXI_LITE_REG_SLAVE -- requirements
Module: axi_lite_reg_slave

Interface
REQ-001 The block SHALL have parameter NREGS, default 16, giving the number of 32-bit registers; it SHALL be a power of two, 2..256.
REQ-002 The block SHALL have parameter ADDR_W, default 32, giving the AXI address width.
REQ-003 clk  input  1  clock; all state SHALL update on posedge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 s_awaddr  input  ADDR_W  write address; s_awvalid  input  1; s_awready  output  1.
REQ-006 s_wdata  input  32  write data; s_wstrb  input  4  byte strobes; s_wvalid  input  1; s_wready  output  1.
REQ-007 s_bresp  output  2  write response; s_bvalid  output  1; s_bready  input  1.
REQ-008 s_araddr  input  ADDR_W  read address; s_arvalid  input  1; s_arready  output  1.
REQ-009 s_rdata  output  32; s_rresp  output  2; s_rvalid  output  1; s_rready  input  1.
REQ-010 regs_flat  output  NREGS*32  current register contents; register i SHALL occupy bits [32*i+31:32*i].

Function
REQ-011 A handshake SHALL occur on a posedge where both valid and ready are 1; valid/ready SHALL be registered outputs and SHALL NOT depend combinationally on inputs.
REQ-012 Word index = addr[1:0] ignored, addr[log2(NREGS)+1:2]; an address >= NREGS*4 SHALL be out-of-range.
REQ-013 Write FSM states: W_IDLE, W_HAVE_A (address held, awaiting data), W_HAVE_D (data held, awaiting address), W_RESP.
REQ-014 s_awready=1 in W_IDLE and W_HAVE_D only; s_wready=1 in W_IDLE and W_HAVE_A only.
REQ-015 W_IDLE: AW only -> W_HAVE_A; W only -> W_HAVE_D; AW and W on the same edge -> W_RESP.
REQ-016 W_HAVE_A on W handshake, or W_HAVE_D on AW handshake -> W_RESP.
REQ-017 The register write SHALL commit on the edge that completes the second handshake (or both together); s_bvalid SHALL be 1 from the following cycle.
REQ-018 Each byte k with s_wstrb[k]=1 SHALL be updated; bytes with strobe 0 SHALL keep their value; wstrb=0 SHALL write nothing and return OKAY.
REQ-019 In-range write: bresp=2'b00 OKAY. Out-of-range write: bresp=2'b10 SLVERR and no register change.
REQ-020 W_RESP: s_bvalid held 1 with stable bresp until the s_bready handshake -> W_IDLE; no AW/W SHALL be accepted in W_RESP.
REQ-021 Read FSM states: R_IDLE (s_arready=1), R_DATA (s_rvalid=1, s_arready=0).
REQ-022 On an AR handshake, rdata/rresp SHALL be captured and s_rvalid SHALL be 1 the next cycle (1-cycle latency); rdata/rresp SHALL be held stable until the s_rready handshake -> R_IDLE.
REQ-023 Out-of-range read: rdata=0, rresp=SLVERR; in-range: rresp=OKAY.
REQ-024 Read and write paths SHALL be fully independent and may complete on the same edge.
REQ-025 An AR handshake on the same edge as a write commit to the same register SHALL return the pre-write value.
REQ-026 The throughput SHALL be one write per 2 cycles and one read per 2 cycles, with the response ready tied high.

Reset
REQ-027 While rst_n=0: all registers 0; s_awready, s_wready, s_arready, s_bvalid, s_rvalid = 0; bresp, rresp, rdata = 0; both FSMs idle.
REQ-028 The ready outputs SHALL rise on the first posedge after rst_n deasserts.
REQ-029 Reset asserted mid-transaction SHALL immediately abandon held address/data and pending responses; the abandoned write SHALL NOT commit.

Verification
REQ-030 Simultaneous AW/W: addr 0x08, data 0xDEADBEEF, strb 0xF -> bvalid next cycle with OKAY; regs_flat word 2 = 0xDEADBEEF.
REQ-031 W then AW 3 cycles later: addr 0x04, data 0x11223344, strb 0x5, reg1 previously 0xAABBCCDD -> reg1 = 0xAA22CC44; no write before the AW handshake.
REQ-032 Out-of-range: write 0x40 (NREGS=16) -> SLVERR with regs unchanged; read 0x40 -> rdata 0 with SLVERR.
REQ-033 Backpressure: bready=0 for 5 cycles -> bvalid stays 1 and awready/wready stay 0; read with rready low -> rdata stable.
REQ-034 Same-edge read/write to reg 3 (old 0x1, new 0x2) -> rdata 0x1; a subsequent read -> 0x2.
REQ-035 rst_n pulse while in W_HAVE_A -> outputs zeroed; the later W handshake SHALL NOT write; regs stay 0.
